// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode/state types and defaults for the ALU arbiter slice.
package alu_pkg;

    localparam int CELL_SIZE_DEFAULT = 16;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011,
        OP_MOD = 3'b100,
        OP_AND = 3'b101,
        OP_OR  = 3'b110,
        OP_XOR = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        CAPT,
        RESP
    } arb_state_e;

    function automatic logic is_div(alu_op_e op);
        return op == OP_DIV || op == OP_MOD;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester-side operation channels and tagged response channel.
interface alu_arbiter_if
    import alu_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int CELL_SIZE = CELL_SIZE_DEFAULT
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]                req_valid;
    logic [N_REQ-1:0]                req_ready;
    logic [N_REQ-1:0][2:0]           req_op;
    logic [N_REQ-1:0][CELL_SIZE-1:0] req_lhs;
    logic [N_REQ-1:0][CELL_SIZE-1:0] req_rhs;
    logic                            rsp_valid;
    logic                            rsp_ready;
    logic [ID_W-1:0]                 rsp_id;
    logic [CELL_SIZE-1:0]            rsp_result;
    logic                            rsp_err;

    modport slave (
        input  req_valid, req_op, req_lhs, req_rhs, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
    );

    modport master (
        output req_valid, req_op, req_lhs, req_rhs, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
    );

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr with wrap.
module rr_arbiter #(
    parameter  int N    = 4,
    localparam int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_idx
);
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[(int'(ptr) + i) % N]) begin
                found     = 1'b1;
                grant_idx = ID_W'((int'(ptr) + i) % N);
            end
        end
        grant[grant_idx] = found;
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one registered ALU among N_REQ requesters.
// Optional ALU_ARB_DIV0_CHECK_EN rejects div/mod by zero without issuing to the ALU.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter  int CELL_SIZE = CELL_SIZE_DEFAULT,
    parameter  int N_REQ     = 4,
    localparam int ID_W      = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    alu_arbiter_if.slave         bus,
    output logic [2:0]           alu_op,
    output logic [CELL_SIZE-1:0] alu_lhs,
    output logic [CELL_SIZE-1:0] alu_rhs,
    input  logic [CELL_SIZE-1:0] alu_result
);
    arb_state_e      state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] id_q;
    logic [ID_W-1:0] win_idx;
    logic [ID_W-1:0] ptr_next;
    logic [N_REQ-1:0] grant;
    logic            accept;
    logic            div0;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req       (bus.req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (win_idx)
    );

    // Strobe is gated by reset so nothing appears accepted while the block is held.
    assign bus.req_ready = (reset_n && state == IDLE) ? grant : '0;
    assign accept        = |bus.req_ready;
    assign ptr_next      = (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

`ifdef ALU_ARB_DIV0_CHECK_EN
    assign div0 = is_div(alu_op_e'(bus.req_op[win_idx])) && bus.req_rhs[win_idx] == '0;
`else
    assign div0 = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            id_q           <= '0;
            alu_op         <= '0;
            alu_lhs        <= '0;
            alu_rhs        <= '0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_id     <= '0;
            bus.rsp_result <= '0;
            bus.rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    rr_ptr <= ptr_next;
                    id_q   <= win_idx;
                    if (div0) begin
                        state          <= RESP;
                        bus.rsp_valid  <= 1'b1;
                        bus.rsp_err    <= 1'b1;
                        bus.rsp_result <= '0;
                        bus.rsp_id     <= win_idx;
                    end else begin
                        state   <= EXEC;
                        alu_op  <= bus.req_op[win_idx];
                        alu_lhs <= bus.req_lhs[win_idx];
                        alu_rhs <= bus.req_rhs[win_idx];
                    end
                end
                EXEC: state <= CAPT;
                CAPT: begin
                    state          <= RESP;
                    bus.rsp_valid  <= 1'b1;
                    bus.rsp_result <= alu_result;
                    bus.rsp_id     <= id_q;
                    bus.rsp_err    <= 1'b0;
                end
                RESP: if (bus.rsp_ready) begin
                    state         <= IDLE;
                    bus.rsp_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed + randomized checks of alu_arbiter against a behavioural model,
// with a registered ALU model attached; covers the ALU_ARB_DIV0_CHECK_EN build when defined.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int N = 4;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [2:0]   alu_op;
    logic [W-1:0] alu_lhs, alu_rhs, alu_result;
    int           checks = 0;
    int           errors = 0;
    int           mptr = 0;
    logic [2:0]   last_op = '0;
    logic [W-1:0] last_lhs = '0, last_rhs = '0;

    alu_arbiter_if #(.N_REQ(N), .CELL_SIZE(W)) bus ();

    alu_arbiter #(.CELL_SIZE(W), .N_REQ(N)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .alu_op     (alu_op),
        .alu_lhs    (alu_lhs),
        .alu_rhs    (alu_rhs),
        .alu_result (alu_result)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_alu(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a * b;
            3'd3: return (b == 0) ? '1 : a / b;
            3'd4: return (b == 0) ? a : a % b;
            3'd5: return a & b;
            3'd6: return a | b;
            default: return a ^ b;
        endcase
    endfunction

    // Registered ALU sharing the arbiter's reset.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) alu_result <= '0;
        else alu_result <= ref_alu(alu_op, alu_lhs, alu_rhs);

    function automatic bit div0_of(logic [2:0] op, logic [W-1:0] b);
`ifdef ALU_ARB_DIV0_CHECK_EN
        return (op == 3'd3 || op == 3'd4) && b == 0;
`else
        return (op != op) && (b != b);
`endif
    endfunction

    function automatic int model_winner();
        for (int i = 0; i < N; i++)
            if (bus.req_valid[(mptr + i) % N]) return (mptr + i) % N;
        return 0;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(int i, logic [2:0] o, logic [W-1:0] a, logic [W-1:0] b);
        bus.req_valid[i] = 1'b1;
        bus.req_op[i]    = o;
        bus.req_lhs[i]   = a;
        bus.req_rhs[i]   = b;
    endtask

    // Called at a negedge with the DUT idle; serves one request, holding rsp_ready low for hold cycles.
    task automatic do_txn(int hold);
        int           w;
        int           cyc = 0;
        bit           dz;
        logic [2:0]   o;
        logic [W-1:0] a, b, exp_r;
        bus.rsp_ready = (hold == 0);
        #1;
        while (bus.req_ready == '0 && cyc < 10) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("grant_timeout", 32'(cyc < 10), 32'd1);
        if (cyc >= 10) return;
        w = model_winner();
        chk("grant_onehot", 32'(bus.req_ready), 32'd1 << w);
        o     = bus.req_op[w];
        a     = bus.req_lhs[w];
        b     = bus.req_rhs[w];
        dz    = div0_of(o, b);
        exp_r = dz ? '0 : ref_alu(o, a, b);
        mptr  = (w + 1) % N;
        @(posedge clk);
        #1;
        bus.req_valid[w] = 1'b0;
        @(negedge clk);
        if (!dz) begin
            chk("exec_no_rsp", 32'(bus.rsp_valid), 32'd0);
            chk("alu_op", 32'(alu_op), 32'(o));
            chk("alu_lhs", 32'(alu_lhs), 32'(a));
            chk("alu_rhs", 32'(alu_rhs), 32'(b));
            chk("exec_no_ready", 32'(bus.req_ready), 32'd0);
            last_op  = o;
            last_lhs = a;
            last_rhs = b;
            @(negedge clk);
            chk("capt_no_rsp", 32'(bus.rsp_valid), 32'd0);
            @(negedge clk);
        end else begin
            chk("div0_alu_op_kept", 32'(alu_op), 32'(last_op));
            chk("div0_alu_lhs_kept", 32'(alu_lhs), 32'(last_lhs));
            chk("div0_alu_rhs_kept", 32'(alu_rhs), 32'(last_rhs));
        end
        chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("rsp_id", 32'(bus.rsp_id), 32'(w));
        chk("rsp_result", 32'(bus.rsp_result), 32'(exp_r));
        chk("rsp_err", 32'(bus.rsp_err), 32'(dz));
        chk("resp_no_ready", 32'(bus.req_ready), 32'd0);
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
            chk("hold_id", 32'(bus.rsp_id), 32'(w));
            chk("hold_result", 32'(bus.rsp_result), 32'(exp_r));
            chk("hold_no_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("rsp_dropped", 32'(bus.rsp_valid), 32'd0);
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
        chk({tag, "_alu_op"}, 32'(alu_op), 32'd0);
        chk({tag, "_alu_lhs"}, 32'(alu_lhs), 32'd0);
        chk({tag, "_alu_rhs"}, 32'(alu_rhs), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_rsp_id"}, 32'(bus.rsp_id), 32'd0);
        chk({tag, "_rsp_result"}, 32'(bus.rsp_result), 32'd0);
        chk({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_lhs   = '0;
        bus.req_rhs   = '0;
        bus.rsp_ready = 1'b1;
        set_req(0, 3'd0, 16'h0001, 16'h0001);
        set_req(1, 3'd1, 16'h0005, 16'h0002);
        set_req(2, 3'd2, 16'h0003, 16'h0003);
        set_req(3, 3'd7, 16'hF0F0, 16'hFFFF);
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) do_txn(0);

        set_req(2, 3'd5, 16'h00FF, 16'h0F0F);
        set_req(0, 3'd6, 16'h1200, 16'h0034);
        do_txn(0);
        do_txn(0);

        set_req(0, 3'd0, 16'd3, 16'd4);
        do_txn(0);
        set_req(1, 3'd1, 16'h0000, 16'h0001);
        do_txn(0);
        set_req(3, 3'd2, 16'h0100, 16'h0100);
        do_txn(0);

        set_req(1, 3'd0, 16'h1234, 16'h1111);
        set_req(2, 3'd7, 16'hAAAA, 16'h5555);
        do_txn(5);
        do_txn(0);

        set_req(2, 3'd3, 16'd9, 16'd0);
        do_txn(0);
        set_req(2, 3'd4, 16'd9, 16'd4);
        do_txn(0);
        set_req(1, 3'd3, 16'd100, 16'd7);
        do_txn(0);

        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < N; i++)
                if (!bus.req_valid[i] && $urandom_range(0, 1) == 1)
                    set_req(i, 3'($urandom_range(0, 7)), 16'($urandom),
                            ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom));
            if (bus.req_valid == '0) set_req(int'($urandom_range(0, N - 1)), 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
            do_txn((n % 5 == 0) ? 2 : 0);
        end
        while (bus.req_valid != '0) do_txn(0);

        set_req(1, 3'd0, 16'h0010, 16'h0020);
        set_req(3, 3'd1, 16'h0100, 16'h0001);
        bus.rsp_ready = 1'b1;
        #1;
        while (bus.req_ready == '0) @(negedge clk);
        @(posedge clk);
        #1;
        bus.req_valid = bus.req_valid & ~bus.req_ready;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        mptr     = 0;
        last_op  = '0;
        last_lhs = '0;
        last_rhs = '0;
        bus.req_valid = '0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("no_rsp_after_reset", 32'(bus.rsp_valid), 32'd0);
        end
        set_req(3, 3'd5, 16'hFF00, 16'h0FF0);
        set_req(0, 3'd0, 16'h7FFF, 16'h0001);
        do_txn(0);
        do_txn(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single registered ALU among `N_REQ` requesters (decode, address unit, microcode sequencer, debug port) using round-robin arbitration. It accepts one operation at a time over a valid/ready handshake and drives the ALU operand/op lines from internal registers. It captures the ALU's one-cycle-latency result and returns it, tagged with the requester index, over a valid/ready response channel.

## Interface
- `CELL_SIZE`, 16, operand/result width in bits.
- `N_REQ`, 4, number of requesters (2..8); `ID_W = $clog2(N_REQ)`.
- `clk`  in  1  clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  per-requester operation pending.
- `req_op`  in  N_REQ×3  per-requester ALU opcode.
- `req_lhs`, `req_rhs`  in  N_REQ×CELL_SIZE  per-requester operands.
- `req_ready`  out  N_REQ  one-hot accept strobe.
- `alu_op`  out  3  opcode to ALU.
- `alu_lhs`, `alu_rhs`  out  CELL_SIZE  operands to ALU.
- `alu_result`  in  CELL_SIZE  ALU registered result.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_id`  out  ID_W  index of the originating requester.
- `rsp_result`  out  CELL_SIZE  operation result.
- `rsp_err`  out  1  operation rejected (divide/modulo by zero).

## Operation
- FSM states and transitions:
  - IDLE → EXEC on accept.
  - EXEC → CAPT unconditionally.
  - CAPT → RESP unconditionally.
  - RESP → IDLE when `rsp_ready`.
- **IDLE:** if any `req_valid`, a round-robin winner is picked starting at `rr_ptr`.
  - `req_ready[winner]` = 1 combinationally. All other `req_ready` bits stay 0 in IDLE and are always 0 in every other state.
  - On that edge, op, lhs, rhs and id are latched into `alu_op`/`alu_lhs`/`alu_rhs`/`id_q`.
  - On that edge, `rr_ptr` ← (winner+1) mod N_REQ.
- **EXEC:** ALU inputs are stable from the registers; the ALU registers its result at the end of the cycle.
- **CAPT:** `alu_result` is valid.
  - `rsp_result` ← `alu_result`, `rsp_id` ← `id_q`, `rsp_err` ← 0, `rsp_valid` ← 1.
- **RESP:** `rsp_*` are held stable until `rsp_valid & rsp_ready` is sampled. At that edge `rsp_valid` ← 0 and the FSM returns to IDLE. No new request is accepted in that same cycle.
- Requesters must hold `req_valid` and payload stable until their `req_ready` strobe. A dropped request is simply not granted.
- `alu_op`/`alu_lhs`/`alu_rhs` retain the last issued values between operations.
- Arithmetic is the ALU's, modulo 2^CELL_SIZE. The arbiter never modifies operands or results.
- Opcode map:
  - 000 add, 001 sub, 010 mul (low CELL_SIZE bits), 011 div, 100 mod.
  - 101 and, 110 or, 111 xor.

## Timing
- Reset (asynchronous, while `reset_n` = 0): FSM = IDLE and `rr_ptr` = 0.
  - `req_ready` = 0 (gated by reset).
  - `alu_op`, `alu_lhs`, `alu_rhs` = 0.
  - `rsp_valid`, `rsp_id`, `rsp_result`, `rsp_err` = 0.
- Reset mid-operation abandons the operation with no response. The shared reset also clears the ALU.
- Latency: for accept edge E0, `rsp_valid` rises after edge E2.
- Minimum issue interval is 4 cycles, with `rsp_ready` tied high.
- Simultaneous requests: the grant order from `rr_ptr`=0 is 0,1,2,…,N_REQ−1, then wraps to 0.
- A lone requester is granted on every IDLE visit, regardless of `rr_ptr`.

## Configuration
- `ALU_ARB_DIV0_CHECK_EN` defined:
  - In IDLE, a winner with op 011 or 100 and rhs = 0 is still accepted (`req_ready` strobe) and `rr_ptr` advances.
  - The FSM goes IDLE → RESP directly, skipping EXEC and CAPT.
  - `rsp_err` = 1, `rsp_result` = 0, `rsp_id` = winner; `rsp_valid` rises after E0.
  - `alu_*` registers are not updated.
- Not defined: such operations are issued normally, `rsp_err` is tied 0, and the result is whatever the ALU produces.

## Structure
- Package `alu_pkg`:
  - `alu_op_e` (3-bit enum, ADD…XOR as above).
  - `arb_state_e` (IDLE, EXEC, CAPT, RESP).
  - `CELL_SIZE_DEFAULT` = 16.
- Sub-module `rr_arbiter`: parameter N, with
  - inputs `req[N]` and `ptr`;
  - outputs `grant` (one-hot) and `grant_idx`.
  - It is purely combinational. `rr_ptr` itself lives in `alu_arbiter`.

## Test plan
- Single requester 0: add 3 + 4 → one `req_ready[0]` pulse; `rsp_valid` after E2 with `rsp_id`=0, `rsp_result`=7, `rsp_err`=0.
- All four requesters valid from reset, ops add 1+1, sub 5−2, mul 3×3, xor F0F0^FFFF:
  - grants in order 0,1,2,3;
  - results 2, 3, 9, 0F0F;
  - a fifth round starts again at requester 0.
- Sub 0 − 1 → `rsp_result` = FFFF. Mul 0x0100 × 0x0100 → 0000.
- Backpressure: `rsp_ready` low for 5 cycles → `rsp_*` stable throughout, no `req_ready` pulses; raise `rsp_ready` → FSM returns to IDLE and accepts the next request.
- With `ALU_ARB_DIV0_CHECK_EN`: div 9/0 from requester 2 → `rsp_valid` after E0, `rsp_err`=1, `rsp_result`=0, `rsp_id`=2. Then mod 9 % 4 → result 1, `rsp_err`=0.
- `reset_n` pulsed low during EXEC → all outputs 0 immediately; no response is produced; the next grant comes from requester 0.
